// File: rtl/spi_fb_pkg.sv
// Shared types and constants for the SPI frame buffer.
// FSM state encoding plus synchroniser depth.
package spi_fb_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX      = 2'd1,
        TX_WAIT = 2'd2,
        TX      = 2'd3
    } fb_state_e;

endpackage

// File: rtl/spi_frame_buffer_if.sv
// SPI pin bundle between host (master) and frame buffer (slave).
interface spi_frame_buffer_if;

    logic SCK;
    logic SSEL;
    logic MOSI;
    logic MISO;

    modport master (
        output SCK,
        output SSEL,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  SCK,
        input  SSEL,
        input  MOSI,
        output MISO
    );

endinterface

// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave PHY: pin synchronisers, edge detect,
// bit counter and rx/tx shift registers.
module spi_slave_phy
    import spi_fb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              sck,
    input  logic              ssel,
    input  logic              mosi,
    input  logic              tx_en,
    input  logic              load,
    input  logic [DATA_W-1:0] load_word,
    output logic              miso,
    output logic              word_valid,
    output logic [DATA_W-1:0] rx_word,
    output logic              word_abort,
    output logic              ssel_fall
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    logic [SYNC_STAGES:0] sck_q;
    logic [SYNC_STAGES:0] ssel_q;
    logic [SYNC_STAGES:0] mosi_q;
    logic                 sck_s, sck_h;
    logic                 ssel_s, ssel_h;
    logic                 sck_rise, sck_fall, ssel_rise;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_W-2:0]    rx_shift;
    logic [DATA_W-1:0]    tx_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= '0;
            ssel_q <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[SYNC_STAGES-1:0], sck};
            ssel_q <= {ssel_q[SYNC_STAGES-1:0], ssel};
            mosi_q <= {mosi_q[SYNC_STAGES-1:0], mosi};
        end
    end

    assign sck_s  = sck_q[SYNC_STAGES-1];
    assign sck_h  = sck_q[SYNC_STAGES];
    assign ssel_s = ssel_q[SYNC_STAGES-1];
    assign ssel_h = ssel_q[SYNC_STAGES];

    assign sck_rise   = ~ssel_s & sck_s & ~sck_h;
    assign sck_fall   = ~ssel_s & ~sck_s & sck_h;
    assign ssel_fall  = ssel_h & ~ssel_s;
    assign ssel_rise  = ~ssel_h & ssel_s;
    assign word_valid = sck_rise & (bit_cnt == BIT_LAST);
    assign word_abort = ssel_rise & (bit_cnt != '0);
    // MOSI history tap is older than the SCK edge, so data is settled
    assign rx_word    = {rx_shift, mosi_q[SYNC_STAGES]};

    // Held low until the select-fall reload has landed
    assign miso = tx_en & ~ssel_s & ~ssel_h & tx_shift[DATA_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else begin
            if (clear || ssel_s)
                bit_cnt <= '0;
            else if (sck_rise)
                bit_cnt <= word_valid ? '0 : bit_cnt + 1'b1;
            if (sck_rise)
                rx_shift <= rx_word[DATA_W-2:0];
            // No shift on the fall that follows a word boundary
            if (load)
                tx_shift <= load_word;
            else if (sck_fall && bit_cnt != '0)
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/spi_frame_buffer.sv
// SPI-slave frame buffer: receives DEPTH samples, holds them
// for local readout, then returns them to the host in order.
module spi_frame_buffer
    import spi_fb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_frame_buffer_if.slave spi,
    input  logic              clear,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        state_o,
    output logic              frame_ready,
    output logic              frame_done,
    output logic              word_abort
);

    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    fb_state_e         state;
    logic [AW-1:0]     wr_idx, wr_next;
    logic [AW-1:0]     tx_idx, tx_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              word_valid, phy_abort, ssel_fall;
    logic              load, in_tx, in_wait;
    logic [DATA_W-1:0] rx_word, load_word;

    assign in_tx   = (state == TX);
    assign in_wait = (state == TX_WAIT);
    assign wr_next = (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
    assign tx_next = (tx_idx == LAST) ? '0 : tx_idx + 1'b1;
    assign state_o = state;

    spi_slave_phy #(
        .DATA_W (DATA_W)
    ) u_phy (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .sck        (spi.SCK),
        .ssel       (spi.SSEL),
        .mosi       (spi.MOSI),
        .tx_en      (in_tx),
        .load       (load),
        .load_word  (load_word),
        .miso       (spi.MISO),
        .word_valid (word_valid),
        .rx_word    (rx_word),
        .word_abort (phy_abort),
        .ssel_fall  (ssel_fall)
    );

    always_comb begin
        load      = 1'b0;
        load_word = mem[0];
        if (!clear) begin
            if (in_wait && ssel_fall) begin
                load = 1'b1;
            end else if (in_tx && word_valid && tx_idx != LAST) begin
                load      = 1'b1;
                load_word = mem[tx_next];
            end else if (in_tx && ssel_fall) begin
                load      = 1'b1;
                load_word = mem[tx_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clear && state == RX && word_valid)
            mem[wr_idx] <= rx_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if ({1'b0, rd_addr} < DEPTH_C)
            rd_data <= mem[rd_addr];
        else
            rd_data <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RX_IDLE;
            wr_idx      <= '0;
            tx_idx      <= '0;
            frame_ready <= 1'b0;
            frame_done  <= 1'b0;
            word_abort  <= 1'b0;
        end else if (clear) begin
            state       <= RX_IDLE;
            wr_idx      <= '0;
            tx_idx      <= '0;
            frame_ready <= 1'b0;
            frame_done  <= 1'b0;
            word_abort  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            word_abort <= phy_abort;
            unique case (state)
                RX_IDLE: begin
                    if (ssel_fall)
                        state <= RX;
                end
                RX: begin
                    if (word_valid) begin
                        wr_idx <= wr_next;
                        if (wr_idx == LAST) begin
                            state       <= TX_WAIT;
                            frame_ready <= 1'b1;
                        end
                    end
                end
                TX_WAIT: begin
                    if (ssel_fall) begin
                        tx_idx <= '0;
                        state  <= TX;
                    end
                end
                TX: begin
                    if (word_valid) begin
                        tx_idx <= tx_next;
                        if (tx_idx == LAST) begin
                            state       <= RX_IDLE;
                            frame_ready <= 1'b0;
                            frame_done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_buffer.sv
// Directed bench for spi_frame_buffer: 8x4 and 12x5 instances
// sharing host SPI pins, checked with immediate assertions.
module tb_spi_frame_buffer;

    localparam time TCLK = 10;
    localparam time HALF = 50;

    logic clk = 1'b0;
    always #(TCLK/2) clk = ~clk;

    logic        rst_n, sck, ssel, mosi, clear4, clear5, use5;
    logic [1:0]  rd_addr4;
    logic [2:0]  rd_addr5;
    logic [7:0]  rd_data4;
    logic [11:0] rd_data5;
    logic [1:0]  st4, st5;
    logic        fr4, fd4, wa4, fr5, fd5, wa5;
    int          nvec = 0;
    int          nerr = 0;
    int          n_fd4 = 0;
    int          n_wa4 = 0;
    int          n_fd5 = 0;
    int          base;
    logic [15:0] got;

    spi_frame_buffer_if if4 ();
    spi_frame_buffer_if if5 ();

    assign if4.SCK  = sck;
    assign if4.SSEL = ssel;
    assign if4.MOSI = mosi;
    assign if5.SCK  = sck;
    assign if5.SSEL = ssel;
    assign if5.MOSI = mosi;

    spi_frame_buffer #(.DATA_W(8), .DEPTH(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi         (if4),
        .clear       (clear4),
        .rd_addr     (rd_addr4),
        .rd_data     (rd_data4),
        .state_o     (st4),
        .frame_ready (fr4),
        .frame_done  (fd4),
        .word_abort  (wa4)
    );

    spi_frame_buffer #(.DATA_W(12), .DEPTH(5)) dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi         (if5),
        .clear       (clear5),
        .rd_addr     (rd_addr5),
        .rd_data     (rd_data5),
        .state_o     (st5),
        .frame_ready (fr5),
        .frame_done  (fd5),
        .word_abort  (wa5)
    );

    always @(negedge clk) begin
        if (fd4) n_fd4 <= n_fd4 + 1;
        if (wa4) n_wa4 <= n_wa4 + 1;
        if (fd5) n_fd5 <= n_fd5 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [15:0] w, input int n, input int nb,
                        output logic [15:0] r);
        r = '0;
        for (int i = 0; i < nb; i++) begin
            mosi = w[n-1-i];
            #HALF;
            r = {r[14:0], (use5 ? if5.MISO : if4.MISO)};
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic sel(input logic v);
        ssel = v;
        #(2*HALF);
    endtask

    task automatic rd4(input logic [1:0] a, input logic [7:0] exp,
                       input string tag);
        rd_addr4 = a;
        #(2*TCLK);
        chk(tag, rd_data4, exp);
    endtask

    task automatic rd5(input logic [2:0] a, input logic [11:0] exp,
                       input string tag);
        rd_addr5 = a;
        #(2*TCLK);
        chk(tag, rd_data5, exp);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sck = 1'b0; ssel = 1'b1; mosi = 1'b0;
        clear4 = 1'b0; clear5 = 1'b0; use5 = 1'b0;
        rd_addr4 = '0; rd_addr5 = '0;
        #(2*TCLK);
        chk("rst_state", st4, 0);
        chk("rst_ready", fr4, 0);
        chk("rst_miso", if4.MISO, 0);
        chk("rst_rd", rd_data4, 0);
        rst_n = 1'b1;
        #(5*TCLK);

        // receive A5 3C FF 01
        sel(1'b0);
        xfer(16'hA5, 8, 8, got);
        xfer(16'h3C, 8, 8, got);
        xfer(16'hFF, 8, 8, got);
        xfer(16'h01, 8, 8, got);
        chk("rx_state", st4, 2);
        chk("rx_ready", fr4, 1);
        rd4(2'd1, 8'h3C, "rd1");
        rd4(2'd3, 8'h01, "rd3");
        sel(1'b1);

        // transmit back in one burst
        sel(1'b0);
        chk("tx_state", st4, 3);
        xfer(16'h0, 8, 8, got); chk("tx_w0", got, 16'hA5);
        xfer(16'h0, 8, 8, got); chk("tx_w1", got, 16'h3C);
        xfer(16'h0, 8, 8, got); chk("tx_w2", got, 16'hFF);
        xfer(16'h0, 8, 8, got); chk("tx_w3", got, 16'h01);
        chk("tx_done_cnt", n_fd4, 1);
        chk("tx_end_state", st4, 0);
        chk("tx_end_ready", fr4, 0);
        chk("tx_end_miso", if4.MISO, 0);
        sel(1'b1);

        // partial word abort and redo
        sel(1'b0);
        xfer(16'hA5, 8, 8, got);
        xfer(16'h3C, 8, 8, got);
        xfer(16'h77, 8, 5, got);
        sel(1'b1);
        chk("abort_cnt", n_wa4, 1);
        chk("abort_state", st4, 1);
        sel(1'b0);
        xfer(16'h77, 8, 8, got);
        chk("abort_midstate", st4, 1);
        xfer(16'h01, 8, 8, got);
        chk("abort_done_state", st4, 2);
        rd4(2'd2, 8'h77, "abort_rd2");
        rd4(2'd1, 8'h3C, "abort_rd1");
        sel(1'b1);

        // transmit split over two selects
        sel(1'b0);
        xfer(16'h0, 8, 8, got); chk("split_w0", got, 16'hA5);
        xfer(16'h0, 8, 8, got); chk("split_w1", got, 16'h3C);
        sel(1'b1);
        chk("split_gap_miso", if4.MISO, 0);
        sel(1'b0);
        xfer(16'h0, 8, 8, got); chk("split_w2", got, 16'h77);
        xfer(16'h0, 8, 8, got); chk("split_w3", got, 16'h01);
        chk("split_done_cnt", n_fd4, 2);
        chk("split_state", st4, 0);
        sel(1'b1);

        // clear in the middle of a transmit
        sel(1'b0);
        xfer(16'h12, 8, 8, got);
        xfer(16'h34, 8, 8, got);
        xfer(16'h56, 8, 8, got);
        xfer(16'h78, 8, 8, got);
        sel(1'b1);
        sel(1'b0);
        xfer(16'h0, 8, 8, got); chk("clr_w0", got, 16'h12);
        xfer(16'h0, 8, 4, got); chk("clr_nib", got, 16'h3);
        clear4 = 1'b1;
        #TCLK;
        clear4 = 1'b0;
        chk("clr_state", st4, 0);
        chk("clr_ready", fr4, 0);
        chk("clr_miso", if4.MISO, 0);
        #(5*TCLK);
        chk("clr_no_done", n_fd4, 2);
        sel(1'b1);
        chk("clr_no_abort", n_wa4, 1);
        sel(1'b0);
        xfer(16'h9A, 8, 8, got);
        xfer(16'hBC, 8, 8, got);
        xfer(16'hDE, 8, 8, got);
        xfer(16'hF0, 8, 8, got);
        sel(1'b1);
        chk("clr_rx_state", st4, 2);
        rd4(2'd0, 8'h9A, "clr_rd0");
        rd4(2'd3, 8'hF0, "clr_rd3");

        // asynchronous reset in the middle of a word
        sel(1'b0);
        chk("pre_rst_state", st4, 3);
        xfer(16'hABC, 12, 6, got);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_state4", st4, 0);
        chk("arst_ready4", fr4, 0);
        chk("arst_rd4", rd_data4, 0);
        chk("arst_miso4", if4.MISO, 0);
        chk("arst_done4", fd4, 0);
        chk("arst_abort4", wa4, 0);
        chk("arst_state5", st5, 0);
        chk("arst_rd5", rd_data5, 0);
        chk("arst_miso5", if5.MISO, 0);
        ssel = 1'b1;
        #6;
        #(2*TCLK);
        rst_n = 1'b1;
        #(5*TCLK);

        // 12-bit, 5-deep round trip
        use5 = 1'b1;
        sel(1'b0);
        xfer(16'h000, 12, 12, got);
        xfer(16'hFFF, 12, 12, got);
        xfer(16'h800, 12, 12, got);
        xfer(16'h001, 12, 12, got);
        chk("w5_mid_state", st5, 1);
        xfer(16'hABC, 12, 12, got);
        chk("w5_state", st5, 2);
        chk("w5_ready", fr5, 1);
        rd5(3'd4, 12'hABC, "w5_rd4");
        rd5(3'd1, 12'hFFF, "w5_rd1");
        rd5(3'd6, 12'h000, "w5_rd_oob6");
        rd5(3'd2, 12'h800, "w5_rd2");
        rd5(3'd7, 12'h000, "w5_rd_oob7");
        sel(1'b1);
        base = n_fd5;
        sel(1'b0);
        xfer(16'h0, 12, 12, got); chk("w5_tx0", got, 16'h000);
        xfer(16'h0, 12, 12, got); chk("w5_tx1", got, 16'hFFF);
        xfer(16'h0, 12, 12, got); chk("w5_tx2", got, 16'h800);
        xfer(16'h0, 12, 12, got); chk("w5_tx3", got, 16'h001);
        xfer(16'h0, 12, 12, got); chk("w5_tx4", got, 16'hABC);
        chk("w5_done_cnt", n_fd5 - base, 1);
        chk("w5_end_state", st5, 0);
        chk("w5_end_ready", fr5, 0);
        sel(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
